// File: rtl/sar_adc_seq.sv
// sar_adc_seq - successive-approximation sequencer for the SAR ADC macro.
//
// Runs a sample window, then a binary search on the capacitive DAC (one
// comparator decision per cycle, MSB first). It can average 2^a conversions
// per result and can run back-to-back in continuous mode.
//
// Ports:
//   CLK      conversion clock; all state changes on the rising edge
//   RST      asynchronous, active-high reset
//   GO       level start request, only looked at in IDLE
//   CONT     continuous mode, looked at when a result is produced
//   AVG_SEL  averaging exponent a (clamped to MAX_AVG_LOG2)
//   CMP      comparator: 1 = analog input >= DAC trial level
//   SAMPLE   sample-switch enable
//   DAC      registered trial code driven to the cap DAC
//   RESULT   averaged result, held until the next VALID
//   VALID    one-cycle strobe, RESULT was updated for this cycle
//   BUSY     high whenever the sequencer is not idle
//
// state  | meaning
// IDLE   | waiting for GO, DAC parked at 0
// SAMPLE | sample switch closed for SAMPLE_CYCLES cycles
// CONV   | one comparator decision per cycle, MSB first

module sar_adc_seq #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int MAX_AVG_LOG2  = 3,
    parameter int AW            = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    input  logic             CONT,
    input  logic [AW-1:0]    AVG_SEL,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] RESULT,
    output logic             VALID,
    output logic             BUSY
);

    localparam int ACCW = NBITS + MAX_AVG_LOG2;
    localparam int CW   = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
    localparam int SCW  = $clog2(SAMPLE_CYCLES + 1);
    localparam int BW   = $clog2(NBITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONV
    } state_t;

    state_t          state;
    logic [SCW-1:0]  samp_cnt;   // sample cycles left after the current one
    logic [BW-1:0]   bit_idx;    // index of the bit under trial
    logic [CW-1:0]   rem;        // conversions still to run after this one
    logic [AW-1:0]   a_eff;
    logic [ACCW-1:0] acc;

    logic [NBITS-1:0] trial_mask;
    logic [NBITS-1:0] decided;
    logic [ACCW-1:0]  sum;
    logic [NBITS-1:0] avg;

    function automatic logic [AW-1:0] clamp_avg(input logic [AW-1:0] a);
        if (int'(a) > MAX_AVG_LOG2)
            return AW'(MAX_AVG_LOG2);
        return a;
    endfunction

    // Number of repeats after the first conversion: 2^a - 1.
    function automatic logic [CW-1:0] reps(input logic [AW-1:0] a);
        return CW'((32'd1 << a) - 32'd1);
    endfunction

    // Code with the current trial bit resolved by the comparator.
    always_comb begin
        trial_mask = NBITS'(1) << bit_idx;
        decided    = CMP ? DAC : (DAC & ~trial_mask);
        sum        = acc + ACCW'(decided);
        avg        = NBITS'(sum >> a_eff);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            SAMPLE   <= 1'b0;
            DAC      <= '0;
            RESULT   <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            samp_cnt <= '0;
            bit_idx  <= '0;
            rem      <= '0;
            a_eff    <= '0;
            acc      <= '0;
        end else begin
            VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (GO) begin
                        state    <= ST_SAMPLE;
                        SAMPLE   <= 1'b1;
                        BUSY     <= 1'b1;
                        DAC      <= '0;
                        a_eff    <= clamp_avg(AVG_SEL);
                        rem      <= reps(clamp_avg(AVG_SEL));
                        acc      <= '0;
                        samp_cnt <= SCW'(SAMPLE_CYCLES - 1);
                    end
                end

                ST_SAMPLE: begin
                    if (samp_cnt == '0) begin
                        state   <= ST_CONV;
                        SAMPLE  <= 1'b0;
                        DAC     <= NBITS'(1) << (NBITS - 1);
                        bit_idx <= BW'(NBITS - 1);
                    end else begin
                        samp_cnt <= samp_cnt - SCW'(1);
                    end
                end

                ST_CONV: begin
                    if (bit_idx != '0) begin
                        DAC     <= decided | (trial_mask >> 1);
                        bit_idx <= bit_idx - BW'(1);
                    end else begin
                        samp_cnt <= SCW'(SAMPLE_CYCLES - 1);
                        DAC      <= '0;
                        if (rem != '0) begin
                            // Internal repeat of the averaging set.
                            rem    <= rem - CW'(1);
                            acc    <= sum;
                            state  <= ST_SAMPLE;
                            SAMPLE <= 1'b1;
                        end else begin
                            RESULT <= avg;
                            VALID  <= 1'b1;
                            acc    <= '0;
                            if (CONT) begin
                                state  <= ST_SAMPLE;
                                SAMPLE <= 1'b1;
                                a_eff  <= clamp_avg(AVG_SEL);
                                rem    <= reps(clamp_avg(AVG_SEL));
                            end else begin
                                state <= ST_IDLE;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq - directed self-checking bench for sar_adc_seq.
// A second instance with MAX_AVG_LOG2=1 shares the stimulus so the
// averaging clamp can be observed alongside the main instance.

module tb_sar_adc_seq;

    logic       clk;
    logic       rst;
    logic       go;
    logic       cont;
    logic [1:0] avg_sel;
    logic [7:0] vin;

    logic       cmp;
    logic       sample;
    logic [7:0] dac;
    logic [7:0] result;
    logic       valid;
    logic       busy;

    logic       cmp_m1;
    logic       sample_m1;
    logic [7:0] dac_m1;
    logic [7:0] result_m1;
    logic       valid_m1;
    logic       busy_m1;

    int n_tests;
    int n_fail;

    logic [7:0] dac_seq [8];

    assign cmp    = (vin >= dac);
    assign cmp_m1 = (vin >= dac_m1);

    sar_adc_seq #(.NBITS(8), .SAMPLE_CYCLES(2), .MAX_AVG_LOG2(3), .AW(2)) dut (
        .CLK(clk), .RST(rst), .GO(go), .CONT(cont), .AVG_SEL(avg_sel),
        .CMP(cmp), .SAMPLE(sample), .DAC(dac), .RESULT(result),
        .VALID(valid), .BUSY(busy)
    );

    sar_adc_seq #(.NBITS(8), .SAMPLE_CYCLES(2), .MAX_AVG_LOG2(1), .AW(2)) dut_m1 (
        .CLK(clk), .RST(rst), .GO(go), .CONT(cont), .AVG_SEL(avg_sel),
        .CMP(cmp_m1), .SAMPLE(sample_m1), .DAC(dac_m1), .RESULT(result_m1),
        .VALID(valid_m1), .BUSY(busy_m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse GO at edge 0, check VALID in cycles 1..vc and RESULT/BUSY at vc.
    task automatic run_frame(input string name, input logic [7:0] v, input logic [1:0] a,
                             input int vc, input logic [7:0] exp,
                             output int m1_vc, output logic [7:0] m1_res);
        vin     = v;
        avg_sel = a;
        cont    = 1'b0;
        m1_vc   = 0;
        m1_res  = 8'h00;
        @(negedge clk) go = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= vc; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
            if (valid_m1 && m1_vc == 0) begin
                m1_vc  = c;
                m1_res = result_m1;
            end
            chk($sformatf("%s valid c%0d", name, c), 32'(valid), 32'(c == vc));
            if (c == vc) begin
                chk($sformatf("%s result", name), 32'(result), 32'(exp));
                chk($sformatf("%s busy", name), 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int         m1_vc;
        logic [7:0] m1_res;

        n_tests = 0;
        n_fail  = 0;
        dac_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst     = 1'b1;
        go      = 1'b0;
        cont    = 1'b0;
        avg_sel = 2'd0;
        vin     = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst sample", 32'(sample), 32'd0);
        chk("rst dac", 32'(dac), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single conversion, full per-cycle trace.
        vin     = 8'hA5;
        avg_sel = 2'd0;
        go      = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
            chk($sformatf("single sample c%0d", c), 32'(sample), 32'(c >= 1 && c <= 2));
            chk($sformatf("single valid c%0d", c), 32'(valid), 32'(c == 11));
            chk($sformatf("single busy c%0d", c), 32'(busy), 32'(c <= 10));
            if (c >= 3 && c <= 10)
                chk($sformatf("single dac c%0d", c), 32'(dac), 32'(dac_seq[c-3]));
            else
                chk($sformatf("single dac c%0d", c), 32'(dac), 32'd0);
            if (c == 11)
                chk("single result", 32'(result), 32'hA5);
        end

        // Asynchronous reset in the middle of a conversion.
        vin = 8'h77;
        go  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
        end
        chk("async pre dac", 32'(dac), 32'h60);
        chk("async pre busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async sample", 32'(sample), 32'd0);
        chk("async dac", 32'(dac), 32'd0);
        chk("async result", 32'(result), 32'd0);
        chk("async valid", 32'(valid), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Averaging of four conversions; the MAX_AVG_LOG2=1 copy averages two.
        vin     = 8'h10;
        avg_sel = 2'd2;
        go      = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
            chk($sformatf("avg sample c%0d", c), 32'(sample),
                32'((c <= 40) && (((c - 1) % 10) < 2)));
            chk($sformatf("avg valid c%0d", c), 32'(valid), 32'(c == 41));
            if (c == 41) chk("avg result", 32'(result), 32'h11);
            if (c == 21) begin
                chk("avg m1 valid", 32'(valid_m1), 32'd1);
                chk("avg m1 result", 32'(result_m1), 32'h10);
            end
            if (c == 11 || c == 21) vin = 8'h11;
            if (c == 31) vin = 8'h12;
        end

        // Boundary codes and the averaging clamp.
        run_frame("full", 8'hFF, 2'd0, 11, 8'hFF, m1_vc, m1_res);
        run_frame("zero", 8'h00, 2'd0, 11, 8'h00, m1_vc, m1_res);
        run_frame("avg8", 8'hFF, 2'd3, 81, 8'hFF, m1_vc, m1_res);
        chk("clamp m1 valid cycle", 32'(m1_vc), 32'd21);
        chk("clamp m1 result", 32'(m1_res), 32'hFF);

        // Continuous mode, CONT dropped mid-frame.
        vin     = 8'h3C;
        avg_sel = 2'd0;
        cont    = 1'b1;
        @(negedge clk) go = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
            chk($sformatf("cont valid c%0d", c), 32'(valid), 32'(c == 11 || c == 21 || c == 31));
            chk($sformatf("cont busy c%0d", c), 32'(busy), 32'(c <= 30));
            if (c == 11 || c == 21) begin
                chk($sformatf("cont sample c%0d", c), 32'(sample), 32'd1);
                chk($sformatf("cont result c%0d", c), 32'(result), 32'h3C);
            end
            if (c == 31) chk("cont result c31", 32'(result), 32'h3C);
            if (c == 25) cont = 1'b0;
        end

        // Reset mid-CONV with GO held, then restart on release.
        vin = 8'h5A;
        @(negedge clk) go = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst6 busy", 32'(busy), 32'd0);
        chk("rst6 dac", 32'(dac), 32'd0);
        chk("rst6 result", 32'(result), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst6 hold valid %0d", c), 32'(valid), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("rst6 valid c%0d", c), 32'(valid), 32'(c == 11));
            if (c == 10) chk("rst6 result held", 32'(result), 32'd0);
            if (c == 11) chk("rst6 result", 32'(result), 32'h5A);
        end
        go = 1'b0;
        repeat (15) @(negedge clk);
        chk("final busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
- Parametrised successive-approximation sequencer for the SAR ADC macro. Replaces the fixed 5-bit internal SAR logic.
- Drives the sample switch and the capacitive-DAC trial code, and reads the comparator one bit per cycle.
- Adds a programmable sample window, power-of-two averaging and a continuous-conversion mode.
- RESULT/VALID/SAMPLE go to the pads and to the SPI readback bus unchanged.

Parameters:
- NBITS, 8, conversion resolution in bits (≥2).
- SAMPLE_CYCLES, 2, cycles SAMPLE is held high per conversion (≥1).
- MAX_AVG_LOG2, 3, largest averaging exponent; accumulator width is NBITS+MAX_AVG_LOG2.
- AW, 2, width of AVG_SEL.

Ports:
- CLK  input  1  conversion clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- GO  input  1  level start request, sampled only in IDLE.
- CONT  input  1  continuous mode, sampled at frame end.
- AVG_SEL  input  AW  averaging exponent a; 2^a conversions per result.
- CMP  input  1  comparator: 1 = input ≥ DAC trial level.
- SAMPLE  output  1  sample-switch enable.
- DAC  output  NBITS  registered trial code to the cap DAC.
- RESULT  output  NBITS  averaged result, held until next VALID.
- VALID  output  1  one-cycle strobe, RESULT updated this cycle.
- BUSY  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: asynchronous, active-high. Forces state=IDLE and clears SAMPLE, DAC, RESULT, VALID, BUSY, accumulator and counters to 0. A reset mid-frame aborts the frame with no VALID.
- States and transitions:
  - IDLE → SAMPLE on an edge with GO=1. On that edge, latch a_eff = min(AVG_SEL, MAX_AVG_LOG2), clear the accumulator and clear the frame count.
  - SAMPLE: lasts exactly SAMPLE_CYCLES cycles with SAMPLE=1 and DAC=0. On its last edge, DAC ← 1<<(NBITS-1).
  - CONV: lasts exactly NBITS cycles. In cycle k (k=0..NBITS-1) DAC shows the bits decided so far OR'd with bit NBITS-1-k. On each CONV edge, CMP is sampled: CMP=1 keeps the trial bit, CMP=0 clears it. The next lower bit is then set as the new trial bit, except after the last bit.
- Frame end (last CONV edge):
  - final = decided code including bit 0.
  - acc ← acc + final (width NBITS+MAX_AVG_LOG2, no overflow possible).
  - If count < 2^a_eff − 1: count++ and go to SAMPLE (an internal repeat, no VALID).
  - Otherwise: RESULT ← (acc+final) >> a_eff (truncating), VALID=1 for the following cycle only, and acc and count are cleared.
    - If CONT=1, go to SAMPLE and re-latch a_eff from the current AVG_SEL.
    - If CONT=0, go to IDLE; DAC ← 0.
- Timing: with GO seen at edge 0, SAMPLE is high in cycles 1..S (S = SAMPLE_CYCLES), CONV runs in cycles S+1..S+NBITS, and VALID is high in cycle S+NBITS+1.
  - In continuous mode, SAMPLE of the next frame coincides with VALID, giving one result every (S+NBITS)·2^a_eff cycles.
- GO is ignored outside IDLE. GO held high with CONT=0 restarts on the edge where state is IDLE, so there is one idle cycle between frames.
- CONT or AVG_SEL changed mid-frame takes effect only at the frame end; the current averaging set always completes.
- BUSY is registered, equals state ≠ IDLE, and is high in cycles 1..end of last CONV.

Test Plan:
Bench config: NBITS=8, S=2, MAX_AVG_LOG2=3, AW=2. Comparator model: CMP = (vin ≥ DAC).
1. Reset: assert RST asynchronously mid-cycle → SAMPLE, DAC, RESULT, VALID and BUSY read 0 immediately, with no clock edge needed.
2. Single conversion: vin=0xA5, AVG_SEL=0, GO pulsed at edge 0 → SAMPLE in cycles 1–2; DAC sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 in cycles 3–10; VALID only in cycle 11 with RESULT=0xA5; BUSY=0 from cycle 11.
3. Averaging: AVG_SEL=2, vin per frame 0x10,0x11,0x11,0x12 → no VALID until cycle 41; then RESULT=0x11 (0x44>>2); SAMPLE re-asserts in cycles 11, 21, 31.
4. Boundaries:
   - vin=0xFF gives 0xFF; vin=0x00 gives 0x00.
   - AVG_SEL=3 (clamp not exceeded) with vin=0xFF → RESULT=0xFF, VALID at cycle 81, no overflow.
   - Rerun with MAX_AVG_LOG2=1 and AVG_SEL=3 → clamped to 2 conversions, VALID at cycle 21.
5. Continuous: CONT=1, AVG_SEL=0, vin=0x3C → VALID at cycles 11, 21, 31… each with RESULT=0x3C. Drop CONT in cycle 25 → the frame ending cycle 30 completes (VALID at 31), then IDLE, BUSY=0.
6. Reset mid-CONV: RST in cycle 6 → immediate IDLE, no VALID, RESULT stays 0. GO held high after RST release → new frame, correct RESULT 11 cycles later.
